post_pcap_bram_replay_pacer: RTL

//  Read-side counterpart of the pcap store path. Sits between the BRAM replay reader and the TX

---
 rtl/post_pcap_bram_replay_pacer.sv | 69 ++++++
 1 files changed

// File: rtl/post_pcap_bram_replay_pacer.sv
// post_pcap_bram_replay_pacer: holds each replayed packet's first beat until its recorded inter-packet delay has elapsed
module post_pcap_bram_replay_pacer #(
    parameter int C_M_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_TS_SHIFT           = 0
) (
    input  logic                                axis_aclk,
    input  logic                                axis_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]     s_axis_tuser,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]     m_axis_tuser,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    input  logic                                pace_en,
    output logic [31:0]                         replay_pkt_cnt,
    output logic [31:0]                         late_pkt_cnt
);
    typedef enum logic {IDLE, PKT} state_t;
    state_t      state_q, state_d;
    logic [39:0] gap_q, gap_d, delay_ticks;
    logic [31:0] replay_q, replay_d, late_q, late_d;
    logic        go, xfer, first, late;
    logic        unused_tuser;
    assign unused_tuser = ^s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:64];
    assign delay_ticks  = {8'b0, s_axis_tuser[63:32]} << C_TS_SHIFT;
    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;
    assign m_axis_tuser = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, s_axis_tuser[31:0]};
    assign replay_pkt_cnt = replay_q;
    assign late_pkt_cnt   = late_q;
    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state_q  <= IDLE;
            gap_q    <= '1;
            replay_q <= '0;
            late_q   <= '0;
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            replay_q <= replay_d;
            late_q   <= late_d;
        end
    end
    always_comb begin
        state_d = xfer ? (s_axis_tlast ? IDLE : PKT) : state_q;
    end
    // gating applies only between packets; reset forces both handshakes low
    always_comb begin
        go            = ~pace_en | (delay_ticks <= gap_q);
        m_axis_tvalid = ~axis_reset & s_axis_tvalid & ((state_q == PKT) | go);
        s_axis_tready = ~axis_reset & m_axis_tready & ((state_q == PKT) | go);
        xfer          = m_axis_tvalid & m_axis_tready;
        first         = xfer & (state_q == IDLE);
        late          = first & pace_en & (|delay_ticks) & (gap_q > delay_ticks);
        gap_d         = first ? 40'd1 : (&gap_q ? gap_q : gap_q + 40'd1);
        replay_d      = first ? replay_q + 32'd1 : replay_q;
        late_d        = late ? late_q + 32'd1 : late_q;
    end
endmodule
